// File: rtl/chord_sequencer_pkg.sv
// chord_sequencer_pkg
//   Shared music definitions for the chord sequencer and its song ROM:
//   the ROM word layout (bit positions and field widths), the unpacked
//   entry struct, and the sequencer FSM state encoding.
package chord_sequencer_pkg;

  // ROM word layout, MSB first:
  // [35] end | [34:29] n1 | [28:23] n2 | [22:17] n3 | [16:11] n4 | [10:5] dur | [4:2] meta | [1:0] num
  localparam int WORD_W   = 36;
  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 6;
  localparam int META_W   = 3;
  localparam int NUM_W    = 2;

  localparam int END_BIT  = 35;
  localparam int N1_LSB   = 29;
  localparam int N2_LSB   = 23;
  localparam int N3_LSB   = 17;
  localparam int N4_LSB   = 11;
  localparam int DUR_LSB  = 5;
  localparam int META_LSB = 2;
  localparam int NUM_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_LOAD    = 3'd3,
    ST_PLAYING = 3'd4
  } state_t;

  typedef struct packed {
    logic              end_mark;
    logic [NOTE_W-1:0] note1;
    logic [NOTE_W-1:0] note2;
    logic [NOTE_W-1:0] note3;
    logic [NOTE_W-1:0] note4;
    logic [DUR_W-1:0]  duration;
    logic [META_W-1:0] metadata;
    logic [NUM_W-1:0]  num_notes;
  } entry_t;

  // Slice a raw ROM word into named fields using the layout above.
  function automatic entry_t unpack_entry(input logic [WORD_W-1:0] w);
    entry_t e;
    e.end_mark  = w[END_BIT];
    e.note1     = w[N1_LSB   +: NOTE_W];
    e.note2     = w[N2_LSB   +: NOTE_W];
    e.note3     = w[N3_LSB   +: NOTE_W];
    e.note4     = w[N4_LSB   +: NOTE_W];
    e.duration  = w[DUR_LSB  +: DUR_W];
    e.metadata  = w[META_LSB +: META_W];
    e.num_notes = w[NUM_LSB  +: NUM_W];
    return e;
  endfunction

endpackage

// File: rtl/chord_sequencer.sv
// chord_sequencer
//   Walks the entries of the selected song in an external synchronous ROM
//   and hands each playable entry to notes_player with a one-cycle strobe.
//
// Ports
//   clk, reset       single clock, synchronous active-high reset
//   play             level: high runs, low pauses (LOAD waits for it)
//   next_song        pulse: abort and advance to the next song
//   rom_addr         {current_song, idx} to the song ROM
//   rom_data         ROM word, valid one cycle after rom_addr
//   note1..note4, duration, metadata, num_notes
//                    entry fields, held until the next entry is loaded
//   load_new_note    one-cycle strobe telling notes_player to take the fields
//   play_enable      play gated with LOAD/PLAYING
//   done_with_note   pulse from notes_player when the current entry finishes
//   current_song     selected song
//   song_done        one-cycle pulse at the natural end of a song
//   busy             sequencer is not idle
module chord_sequencer
  import chord_sequencer_pkg::*;
#(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic                          next_song,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [WORD_W-1:0]             rom_data,
  output logic [NOTE_W-1:0]             note1,
  output logic [NOTE_W-1:0]             note2,
  output logic [NOTE_W-1:0]             note3,
  output logic [NOTE_W-1:0]             note4,
  output logic [DUR_W-1:0]              duration,
  output logic [META_W-1:0]             metadata,
  output logic [NUM_W-1:0]              num_notes,
  output logic                          load_new_note,
  output logic                          play_enable,
  input  logic                          done_with_note,
  output logic [SONG_BITS-1:0]          current_song,
  output logic                          song_done,
  output logic                          busy
);

  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

  state_t               state, state_nxt;
  logic [IDX_BITS-1:0]  idx, idx_nxt;
  logic [SONG_BITS-1:0] song_nxt;
  logic                 play_q;
  logic                 play_rise;
  logic                 latch_fields;
  entry_t               word;

  assign word      = unpack_entry(rom_data);
  // play_q clears on reset, so play already high at reset release starts a song.
  assign play_rise = play & ~play_q;

  assign rom_addr    = {current_song, idx};
  assign busy        = (state != ST_IDLE);
  assign play_enable = play & ((state == ST_LOAD) | (state == ST_PLAYING));

  // Strobes are combinational so that done_with_note in cycle N yields
  // FETCH at N+1, WAIT at N+2 and the load strobe in LOAD at N+3.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    song_nxt      = current_song;
    latch_fields  = 1'b0;
    load_new_note = 1'b0;
    song_done     = 1'b0;

    if (next_song) begin
      // Abort wins over everything else in the same cycle, incl. song end.
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      song_nxt  = current_song + SONG_BITS'(1);
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (play_rise) state_nxt = ST_FETCH;
        end
        ST_FETCH: begin
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (word.end_mark) begin
            song_done = 1'b1;
            idx_nxt   = '0;
            state_nxt = ST_IDLE;
          end else if (word.duration == '0) begin
            // Zero-length entries are skipped; skipping past the last
            // slot ends the song just as finishing it would.
            if (idx == IDX_LAST) begin
              song_done = 1'b1;
              idx_nxt   = '0;
              state_nxt = ST_IDLE;
            end else begin
              idx_nxt   = idx + IDX_BITS'(1);
              state_nxt = ST_FETCH;
            end
          end else begin
            latch_fields = 1'b1;
            state_nxt    = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (play) begin
            load_new_note = 1'b1;
            state_nxt     = ST_PLAYING;
          end
        end
        ST_PLAYING: begin
          if (done_with_note) begin
            if (idx == IDX_LAST) begin
              song_done = 1'b1;
              idx_nxt   = '0;
              state_nxt = ST_IDLE;
            end else begin
              idx_nxt   = idx + IDX_BITS'(1);
              state_nxt = ST_FETCH;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    // Reset overrides: no strobe may escape in the cycle reset is sampled.
    if (reset) begin
      load_new_note = 1'b0;
      song_done     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      current_song <= '0;
      play_q       <= 1'b0;
      note1        <= '0;
      note2        <= '0;
      note3        <= '0;
      note4        <= '0;
      duration     <= '0;
      metadata     <= '0;
      num_notes    <= '0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      current_song <= song_nxt;
      play_q       <= play;
      if (latch_fields) begin
        note1     <= word.note1;
        note2     <= word.note2;
        note3     <= word.note3;
        note4     <= word.note4;
        duration  <= word.duration;
        metadata  <= word.metadata;
        num_notes <= word.num_notes;
      end
    end
  end

endmodule

// File: tb/tb_chord_sequencer.sv
// tb_chord_sequencer
//   Directed bench for chord_sequencer with a synchronous song ROM model.
//   A song-level model (scan the ROM for the next playable entry) is
//   checked every cycle; directed steps pin latencies and literal fields.
module tb_chord_sequencer;

  logic        clk = 1'b0;
  logic        reset, play, next_song, done_with_note;
  logic [7:0]  rom_addr;
  logic [35:0] rom_data;
  logic [5:0]  note1, note2, note3, note4, duration;
  logic [2:0]  metadata;
  logic [1:0]  num_notes, current_song;
  logic        load_new_note, play_enable, song_done, busy;

  logic [35:0] rom [0:255];

  int n_checks = 0, n_fail = 0;
  int n_strobe = 0, n_sdone = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  chord_sequencer #(.SONG_BITS(2), .IDX_BITS(6)) dut (
    .clk(clk), .reset(reset), .play(play), .next_song(next_song),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .note1(note1), .note2(note2), .note3(note3), .note4(note4),
    .duration(duration), .metadata(metadata), .num_notes(num_notes),
    .load_new_note(load_new_note), .play_enable(play_enable),
    .done_with_note(done_with_note), .current_song(current_song),
    .song_done(song_done), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [35:0] mk(bit e, int n1, int n2, int n3, int n4,
                                     int dur, int meta, int num);
    return {e, 6'(n1), 6'(n2), 6'(n3), 6'(n4), 6'(dur), 3'(meta), 2'(num)};
  endfunction

  // Index of the next playable entry at or after pos, or 64 if the song ends first.
  function automatic int scan(int song, int pos);
    logic [35:0] w;
    for (int k = pos; k < 64; k++) begin
      w = rom[song*64 + k];
      if (w[35]) return 64;
      if (w[10:5] != 6'd0) return k;
    end
    return 64;
  endfunction

  // ---------------- song-level model and per-cycle compare ----------------
  int m_song = 0, m_pos = 0, m_cur = 0;
  bit m_active = 1'b0;
  logic [35:0] m_word = '0;

  initial begin : cmp
    int eff, k;
    logic [35:0] w;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (armed) begin
          chk("reset_no_strobe", load_new_note, 0);
          chk("reset_no_song_done", song_done, 0);
        end
        m_song = 0; m_pos = 0; m_cur = 0; m_active = 0; m_word = '0;
      end else begin
        chk("current_song", current_song, m_song);
        if (!play) chk("play_enable_needs_play", play_enable, 0);
        eff = (done_with_note && m_active) ? m_cur + 1 : m_pos;
        if (next_song) begin
          chk("next_song_no_strobe", load_new_note, 0);
          chk("next_song_no_song_done", song_done, 0);
          m_song = (m_song + 1) % 4; m_pos = 0; m_active = 0;
        end else begin
          if (load_new_note) begin
            n_strobe++;
            chk("strobe_with_play", play, 1);
            k = scan(m_song, m_pos);
            chk("strobe_has_entry", k < 64, 1);
            if (k < 64) begin
              w = rom[m_song*64 + k];
              chk("strobe_addr", rom_addr, m_song*64 + k);
              chk("strobe_fields",
                  {note1, note2, note3, note4, duration, metadata, num_notes}, w[34:0]);
              m_cur = k; m_word = w;
            end
            m_active = 1;
          end else if (m_active) begin
            chk("hold_fields",
                {note1, note2, note3, note4, duration, metadata, num_notes}, m_word[34:0]);
            chk("busy_playing", busy, 1);
            chk("play_enable_playing", play_enable, play);
          end
          if (done_with_note && m_active) begin
            m_pos = eff; m_active = 0;
          end
          if (song_done) begin
            n_sdone++;
            chk("song_done_at_end", scan(m_song, eff), 64);
            m_pos = 0;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_strobe(input string name, input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (load_new_note) begin lat = i; break; end
    end
    if (lat < 0) chk({name, "_strobe_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string name, input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (song_done) begin lat = i; break; end
    end
    if (lat < 0) chk({name, "_song_done_timeout"}, 0, 1);
  endtask

  task automatic pulse_done();
    tick(); done_with_note = 1'b1;
    tick(); done_with_note = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, st, sd;

    for (int i = 0; i < 256; i++) rom[i] = '0;
    // song 0: C; CEG; end
    rom[0]  = mk(0, 40, 0, 0, 0, 1, 0, 0);
    rom[1]  = mk(0, 40, 44, 47, 0, 2, 0, 2);
    rom[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    // song 1: zero-duration entry at idx 1
    rom[64] = mk(0, 10, 0, 0, 0, 3, 0, 0);
    rom[65] = mk(0, 11, 0, 0, 0, 0, 0, 0);
    rom[66] = mk(0, 12, 13, 0, 0, 4, 5, 1);
    rom[67] = mk(0, 14, 0, 0, 0, 2, 0, 0);
    rom[68] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    // song 2: 64 entries, no end marker
    for (int k = 0; k < 64; k++)
      rom[128+k] = mk(0, k, (k+1)%64, (k*3)%64, 63-k, (k%63)+1, k%8, k%4);
    // song 3
    rom[192] = mk(0, 60, 61, 62, 63, 5, 7, 3);
    rom[193] = mk(1, 0, 0, 0, 0, 0, 0, 0);

    reset = 1'b1; play = 1'b0; next_song = 1'b0; done_with_note = 1'b0;
    repeat (3) tick();
    armed = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_song", current_song, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_fields", {note1, note2, note3, note4, duration, metadata, num_notes}, 0);
    chk("rst_play_enable", play_enable, 0);

    // Song 0: two entries then end
    tick(); play = 1'b1;
    wait_strobe("s0e0", 10, lat);
    chk("start_latency", lat, 4);
    chk("s0e0_note1", note1, 40);
    chk("s0e0_dur", duration, 1);
    chk("s0e0_num", num_notes, 0);
    chk("s0e0_addr", rom_addr, 0);
    pulse_done();
    wait_strobe("s0e1", 10, lat);
    chk("done_to_load_latency", lat, 3);
    chk("s0e1_addr", rom_addr, 1);
    chk("s0e1_note2", note2, 44);
    chk("s0e1_note3", note3, 47);
    chk("s0e1_num", num_notes, 2);
    chk("s0e1_dur", duration, 2);
    sd = n_sdone;
    pulse_done();
    wait_done("s0", 10, lat);
    chk("end_latency", lat, 2);
    tick();
    @(negedge clk);
    chk("s0_idle_busy", busy, 0);
    st = n_strobe;
    repeat (10) tick();
    chk("no_restart_strobes", n_strobe - st, 0);
    chk("no_restart_busy", busy, 0);
    chk("s0_song_done_count", n_sdone - sd, 1);

    // Pause: play low while PLAYING and through LOAD
    play = 1'b0; tick(); play = 1'b1;
    wait_strobe("pause_e0", 10, lat);
    tick(); play = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("pause_play_enable", play_enable, 0);
    chk("pause_busy", busy, 1);
    st = n_strobe;
    pulse_done();
    repeat (4) tick();
    chk("load_hold_no_strobe", n_strobe - st, 0);
    @(negedge clk);
    chk("load_hold_play_enable", play_enable, 0);
    chk("load_hold_busy", busy, 1);
    tick(); play = 1'b1;
    wait_strobe("resume", 2, lat);
    chk("resume_latency", lat, 1);
    chk("resume_addr", rom_addr, 1);
    chk("resume_note3", note3, 47);
    tick();
    @(negedge clk);
    chk("resume_play_enable", play_enable, 1);
    pulse_done();
    wait_done("pause_end", 10, lat);

    // next_song while PLAYING song 0
    play = 1'b0; tick(); play = 1'b1;
    wait_strobe("ns_e0", 10, lat);
    tick(); tick();
    sd = n_sdone;
    next_song = 1'b1; tick(); next_song = 1'b0;
    @(negedge clk);
    chk("ns_song", current_song, 1);
    chk("ns_busy", busy, 0);
    repeat (5) tick();
    chk("ns_stays_idle", busy, 0);
    chk("ns_no_song_done", n_sdone - sd, 0);

    // Song 1: skip zero-duration entry
    play = 1'b0; tick(); play = 1'b1;
    wait_strobe("s1e0", 10, lat);
    chk("s1e0_addr", rom_addr, 64);
    chk("s1e0_note1", note1, 10);
    pulse_done();
    wait_strobe("s1e2", 12, lat);
    chk("skip_latency", lat, 5);
    chk("s1e2_addr", rom_addr, 66);
    chk("s1e2_note1", note1, 12);
    chk("s1e2_meta", metadata, 5);
    // next_song coincident with done_with_note
    tick(); tick();
    sd = n_sdone; st = n_strobe;
    done_with_note = 1'b1; next_song = 1'b1;
    tick();
    done_with_note = 1'b0; next_song = 1'b0;
    @(negedge clk);
    chk("ns_done_song", current_song, 2);
    chk("ns_done_busy", busy, 0);
    repeat (6) tick();
    chk("ns_done_no_strobe", n_strobe - st, 0);
    chk("ns_done_no_song_done", n_sdone - sd, 0);

    // Song 2: 64 entries, wraps into song end
    play = 1'b0; tick(); play = 1'b1;
    st = n_strobe; sd = n_sdone;
    for (int i = 0; i < 64; i++) begin
      wait_strobe("s2", 10, lat);
      if (i == 0)  chk("s2_first_addr", rom_addr, 128);
      if (i == 63) begin
        chk("s2_last_addr", rom_addr, 191);
        chk("s2_last_note1", note1, 63);
        tick(); done_with_note = 1'b1;
        @(negedge clk);
        chk("s2_wrap_song_done", song_done, 1);
        tick(); done_with_note = 1'b0;
      end else begin
        pulse_done();
      end
    end
    @(negedge clk);
    chk("s2_strobes", n_strobe - st, 64);
    chk("s2_song_done_count", n_sdone - sd, 1);
    chk("s2_idle", busy, 0);
    chk("s2_addr_wrapped", rom_addr, 128);

    // Reset while holding in LOAD
    play = 1'b0; tick();
    next_song = 1'b1; tick(); next_song = 1'b0;
    @(negedge clk);
    chk("s3_song", current_song, 3);
    tick(); play = 1'b1; tick(); play = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("s3_load_busy", busy, 1);
    chk("s3_latched_note1", note1, 60);
    chk("s3_latched_meta", metadata, 7);
    st = n_strobe;
    tick(); reset = 1'b1; play = 1'b1;
    @(negedge clk);
    chk("rst_load_strobe", load_new_note, 0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("rstl_fields", {note1, note2, note3, note4, duration, metadata, num_notes}, 0);
    chk("rstl_song", current_song, 0);
    chk("rstl_busy", busy, 0);
    chk("rstl_play_enable", play_enable, 0);
    chk("rstl_song_done", song_done, 0);
    chk("rstl_no_strobe", n_strobe - st, 0);
    // play high at reset release counts as a rising edge
    wait_strobe("post_rst", 10, lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_note1", note1, 40);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
